lsu_core: RTL and testbench
===========================

LSU_CORE -- requirements
Module: lsu_core

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, memory data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, maximum cycles a request may remain outstanding before it is abandoned.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 enable  input  1  thread-lane enable; low means the lane is inactive.
REQ-007 cu_state  input  4  compute-unit state: IDLE=0, FETCH=1, DECODE=2, REQ=3, WAIT=4, EXECUTE=5, WRITEBACK=6, DONE=7.
REQ-008 mem_ren  input  1  current instruction is a load.
REQ-009 mem_wen  input  1  current instruction is a store.
REQ-010 rs1_data  input  DATA_WIDTH  address operand; low ADDR_WIDTH bits used.
REQ-011 rs2_data  input  DATA_WIDTH  store data operand.
REQ-012 mem_read_valid  output  1  read request valid.
REQ-013 mem_read_addr  output  ADDR_WIDTH  read address.
REQ-014 mem_read_ready  input  1  read accepted; mem_read_data valid this cycle.
REQ-015 mem_read_data  input  DATA_WIDTH  read return data.
REQ-016 mem_write_valid  output  1  write request valid.
REQ-017 mem_write_addr  output  ADDR_WIDTH  write address.
REQ-018 mem_write_data  output  DATA_WIDTH  write data.
REQ-019 mem_write_ready  input  1  write accepted this cycle.
REQ-020 lsu_state  output  2  IDLE=0, REQ=1, WAIT=2, DONE=3.
REQ-021 lsu_out  output  DATA_WIDTH  last loaded data.
REQ-022 lsu_error  output  1  sticky flag: the last request timed out.

Function
REQ-023 All outputs are registered.
REQ-024 When enable is low, the block holds IDLE, drives both valids low and ignores all other inputs.
REQ-025 IDLE -> REQ on the edge where cu_state==3, enable==1, and mem_ren or mem_wen is set.
- On that edge the block captures the address (rs1_data) and store data (rs2_data), selects the operation, clears lsu_error, asserts the matching valid and zeroes the timeout counter.
- lsu_state therefore reads REQ during the first cycle that cu_state reads 4.
REQ-026 If mem_ren and mem_wen are both set, the request is a read; no write is issued.
REQ-027 If cu_state==3 with neither mem_ren nor mem_wen set, the block stays IDLE and issues nothing.
REQ-028 The valid stays asserted, with address and data stable, throughout REQ and WAIT until the matching ready is sampled high.
REQ-029 In REQ:
- ready high -> DONE;
- otherwise -> WAIT.
REQ-030 In WAIT:
- ready high -> DONE;
- otherwise the counter increments.
REQ-031 Handshake completion (the edge where ready is sampled high): the valid drops on that edge. For a read, lsu_out takes mem_read_data on the same edge.
REQ-032 Ready for the operation not in progress is ignored. Ready sampled while valid is low has no effect.
REQ-033 Timeout, when the counter equals TIMEOUT_CYCLES in WAIT without ready:
- the valid drops;
- lsu_error is set to 1;
- lsu_out is set to 0 for a read, and is unchanged for a write;
- the state goes to DONE.
REQ-034 DONE holds until cu_state==6, then goes to IDLE on the next edge. lsu_out is held until the next completed read.
REQ-035 A new request is accepted only from IDLE. cu_state==3 seen in any other state is ignored.
REQ-036 If cu_state returns to 0 (IDLE) while the block is in REQ, WAIT or DONE, the block aborts to IDLE, drops both valids and leaves lsu_out and lsu_error unchanged.
REQ-037 Stores never modify lsu_out.

Reset
REQ-038 While reset is high, regardless of state, on each edge:
- lsu_state=0;
- both valids=0;
- both addresses=0 and mem_write_data=0;
- lsu_out=0;
- lsu_error=0;
- timeout counter=0.
REQ-039 Reset asserted mid-transaction drops the valid on the same edge; no handshake completes on that edge.

Verification
REQ-040 Load, zero-wait: rs1=0x12, mem_ren=1, cu_state 3 then 4; mem_read_ready=1 in the first valid cycle with data 0xA5. Required:
- mem_read_addr=0x12 for exactly 1 cycle;
- lsu_state 1->3;
- lsu_out=0xA5;
- IDLE after cu_state=6.
REQ-041 Store, 3-cycle wait: rs1=0x40, rs2=0x7E, mem_wen=1; mem_write_ready high on the 4th valid cycle. Required:
- valid high for 4 cycles with address and data stable;
- lsu_state 1,2,2,2 then 3;
- lsu_out unchanged.
REQ-042 Timeout: TIMEOUT_CYCLES=4, load with ready held low. Required:
- valid drops after timeout;
- lsu_error=1;
- lsu_out=0;
- lsu_state=3.
The next accepted request clears lsu_error.
REQ-043 Both ops: mem_ren=mem_wen=1. Required: only mem_read_valid asserts; mem_write_valid stays 0.
REQ-044 Disabled lane: enable=0 through a full load cycle of cu_state. Required: lsu_state stays 0 and no valid asserts.
REQ-045 Reset mid-WAIT: reset pulsed for 1 cycle during WAIT with ready asserted the same cycle. Required:
- all outputs at reset values on the next cycle;
- lsu_out not updated.

Source files
------------

// File: rtl/lsu_mem_if.sv
// Memory-side bus of the LSU: one read channel and one write channel,
// each using a valid/ready handshake.
interface lsu_mem_if #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic                  mem_read_valid;
   logic [ADDR_WIDTH-1:0] mem_read_addr;
   logic                  mem_read_ready;
   logic [DATA_WIDTH-1:0] mem_read_data;
   logic                  mem_write_valid;
   logic [ADDR_WIDTH-1:0] mem_write_addr;
   logic [DATA_WIDTH-1:0] mem_write_data;
   logic                  mem_write_ready;

   // LSU side issues requests
   modport master (
      output mem_read_valid, mem_read_addr,
      input  mem_read_ready, mem_read_data,
      output mem_write_valid, mem_write_addr, mem_write_data,
      input  mem_write_ready
   );

   // Memory side answers them
   modport slave (
      input  mem_read_valid, mem_read_addr,
      output mem_read_ready, mem_read_data,
      input  mem_write_valid, mem_write_addr, mem_write_data,
      output mem_write_ready
   );
endinterface

// File: rtl/lsu_core.sv
// Per-lane load/store unit. Issues one memory read or write per
// compute-unit REQ phase, waits for the handshake or a timeout, and
// holds the result until the compute unit reaches WRITEBACK.
module lsu_core #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  enable,
   input  logic [3:0]            cu_state,
   input  logic                  mem_ren,
   input  logic                  mem_wen,
   input  logic [DATA_WIDTH-1:0] rs1_data,
   input  logic [DATA_WIDTH-1:0] rs2_data,
   lsu_mem_if.master             mem,
   output logic [1:0]            lsu_state,
   output logic [DATA_WIDTH-1:0] lsu_out,
   output logic                  lsu_error
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   localparam logic [3:0] CU_IDLE      = 4'd0;
   localparam logic [3:0] CU_REQ       = 4'd3;
   localparam logic [3:0] CU_WRITEBACK = 4'd6;

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   logic             op_rd;     // operation in flight is a read
   logic [CNT_W-1:0] to_cnt;
   logic             hs_done;

   // Only the ready of the operation in flight can complete it
   assign hs_done = op_rd ? mem.mem_read_ready : mem.mem_write_ready;

   // Request FSM, bus registers, result and error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         lsu_state           <= S_IDLE;
         mem.mem_read_valid  <= 1'b0;
         mem.mem_write_valid <= 1'b0;
         mem.mem_read_addr   <= '0;
         mem.mem_write_addr  <= '0;
         mem.mem_write_data  <= '0;
         lsu_out             <= '0;
         lsu_error           <= 1'b0;
         to_cnt              <= '0;
         op_rd               <= 1'b0;
      end else if (!enable) begin
         lsu_state           <= S_IDLE;
         mem.mem_read_valid  <= 1'b0;
         mem.mem_write_valid <= 1'b0;
      end else if (lsu_state != S_IDLE && cu_state == CU_IDLE) begin
         // Compute unit went back to IDLE: abandon without touching results
         lsu_state           <= S_IDLE;
         mem.mem_read_valid  <= 1'b0;
         mem.mem_write_valid <= 1'b0;
      end else begin
         case (lsu_state)
            S_IDLE: begin
               if (cu_state == CU_REQ && (mem_ren || mem_wen)) begin
                  // Load wins when both are set
                  op_rd     <= mem_ren;
                  lsu_error <= 1'b0;
                  to_cnt    <= '0;
                  lsu_state <= S_REQ;
                  if (mem_ren) begin
                     mem.mem_read_addr  <= rs1_data[ADDR_WIDTH-1:0];
                     mem.mem_read_valid <= 1'b1;
                  end else begin
                     mem.mem_write_addr  <= rs1_data[ADDR_WIDTH-1:0];
                     mem.mem_write_data  <= rs2_data;
                     mem.mem_write_valid <= 1'b1;
                  end
               end
            end
            S_REQ, S_WAIT: begin
               if (hs_done) begin
                  mem.mem_read_valid  <= 1'b0;
                  mem.mem_write_valid <= 1'b0;
                  if (op_rd) lsu_out <= mem.mem_read_data;
                  lsu_state <= S_DONE;
               end else if (lsu_state == S_REQ) begin
                  lsu_state <= S_WAIT;
               end else if (to_cnt == CNT_MAX) begin
                  mem.mem_read_valid  <= 1'b0;
                  mem.mem_write_valid <= 1'b0;
                  lsu_error <= 1'b1;
                  if (op_rd) lsu_out <= '0;
                  lsu_state <= S_DONE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (cu_state == CU_WRITEBACK) lsu_state <= S_IDLE;
            end
            default: lsu_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_core.sv
// Directed bench for lsu_core: load, store with wait, timeout, dual op,
// disabled lane, abort and reset during WAIT.
module tb_lsu_core;
   localparam int AW = 8;
   localparam int DW = 8;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          enable;
   logic [3:0]    cu_state;
   logic          mem_ren, mem_wen;
   logic [DW-1:0] rs1_data, rs2_data;
   logic [1:0]    lsu_state;
   logic [DW-1:0] lsu_out;
   logic          lsu_error;

   int n_chk  = 0;
   int n_fail = 0;

   lsu_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_bus ();

   lsu_core #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .enable(enable), .cu_state(cu_state),
      .mem_ren(mem_ren), .mem_wen(mem_wen),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
      .mem(mem_bus),
      .lsu_state(lsu_state), .lsu_out(lsu_out), .lsu_error(lsu_error)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      int vcnt;
      int cyc;
      reset = 1'b1; enable = 1'b1; cu_state = 4'd0;
      mem_ren = 1'b0; mem_wen = 1'b0; rs1_data = '0; rs2_data = '0;
      mem_bus.mem_read_ready = 1'b0; mem_bus.mem_read_data = '0;
      mem_bus.mem_write_ready = 1'b0;
      tick(); tick();
      chk("rst_state", 32'(lsu_state), 0);
      chk("rst_rvalid", 32'(mem_bus.mem_read_valid), 0);
      chk("rst_wvalid", 32'(mem_bus.mem_write_valid), 0);
      chk("rst_raddr", 32'(mem_bus.mem_read_addr), 0);
      chk("rst_waddr", 32'(mem_bus.mem_write_addr), 0);
      chk("rst_wdata", 32'(mem_bus.mem_write_data), 0);
      chk("rst_out", 32'(lsu_out), 0);
      chk("rst_err", 32'(lsu_error), 0);
      reset = 1'b0;

      // REQ with no operation: nothing issued
      cu_state = 4'd3; tick();
      chk("noop_state", 32'(lsu_state), 0);
      chk("noop_rvalid", 32'(mem_bus.mem_read_valid), 0);
      cu_state = 4'd4; tick();

      // Zero-wait load
      cu_state = 4'd3; mem_ren = 1'b1; rs1_data = 8'h12; tick();
      chk("ld_state_req", 32'(lsu_state), 1);
      chk("ld_rvalid", 32'(mem_bus.mem_read_valid), 1);
      chk("ld_raddr", 32'(mem_bus.mem_read_addr), 32'h12);
      chk("ld_wvalid", 32'(mem_bus.mem_write_valid), 0);
      cu_state = 4'd4; mem_ren = 1'b0;
      mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 8'hA5; tick();
      mem_bus.mem_read_ready = 1'b0;
      chk("ld_state_done", 32'(lsu_state), 3);
      chk("ld_rvalid_drop", 32'(mem_bus.mem_read_valid), 0);
      chk("ld_out", 32'(lsu_out), 32'hA5);
      cu_state = 4'd5; tick();
      chk("ld_hold_done", 32'(lsu_state), 3);
      cu_state = 4'd6; tick();
      chk("ld_idle", 32'(lsu_state), 0);
      cu_state = 4'd0; tick();

      // Store with 3 wait cycles; a stray read ready must be ignored
      cu_state = 4'd3; mem_wen = 1'b1; rs1_data = 8'h40; rs2_data = 8'h7E; tick();
      cu_state = 4'd4; mem_wen = 1'b0; rs1_data = 8'h00; rs2_data = 8'h00;
      mem_bus.mem_read_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk("st_state", 32'(lsu_state), (i == 0) ? 1 : 2);
         chk("st_wvalid", 32'(mem_bus.mem_write_valid), 1);
         chk("st_waddr", 32'(mem_bus.mem_write_addr), 32'h40);
         chk("st_wdata", 32'(mem_bus.mem_write_data), 32'h7E);
         chk("st_rvalid", 32'(mem_bus.mem_read_valid), 0);
         if (i == 3) mem_bus.mem_write_ready = 1'b1;
         tick();
      end
      mem_bus.mem_write_ready = 1'b0; mem_bus.mem_read_ready = 1'b0;
      chk("st_state_done", 32'(lsu_state), 3);
      chk("st_wvalid_drop", 32'(mem_bus.mem_write_valid), 0);
      chk("st_out_kept", 32'(lsu_out), 32'hA5);
      cu_state = 4'd6; tick();
      cu_state = 4'd0; tick();

      // Load timeout: REQ plus WAIT at counts 0..4 keeps valid for 6 cycles
      cu_state = 4'd3; mem_ren = 1'b1; rs1_data = 8'h33; tick();
      cu_state = 4'd4; mem_ren = 1'b0;
      vcnt = 0; cyc = 0;
      while (lsu_state != 2'd3 && cyc < 20) begin
         if (mem_bus.mem_read_valid) vcnt++;
         cyc++;
         tick();
      end
      chk("to_reached_done", 32'(lsu_state), 3);
      chk("to_valid_cycles", 32'(vcnt), TO + 2);
      chk("to_rvalid_drop", 32'(mem_bus.mem_read_valid), 0);
      chk("to_err", 32'(lsu_error), 1);
      chk("to_out_zero", 32'(lsu_out), 0);
      cu_state = 4'd6; tick();
      cu_state = 4'd0; tick();
      chk("to_err_sticky", 32'(lsu_error), 1);

      // Load and store both set: read only; also clears the error
      cu_state = 4'd3; mem_ren = 1'b1; mem_wen = 1'b1;
      rs1_data = 8'h21; rs2_data = 8'h99; tick();
      chk("both_err_clr", 32'(lsu_error), 0);
      chk("both_rvalid", 32'(mem_bus.mem_read_valid), 1);
      chk("both_wvalid", 32'(mem_bus.mem_write_valid), 0);
      chk("both_raddr", 32'(mem_bus.mem_read_addr), 32'h21);
      cu_state = 4'd4; mem_ren = 1'b0; mem_wen = 1'b0;
      mem_bus.mem_write_ready = 1'b1; tick();
      chk("both_wait", 32'(lsu_state), 2);
      chk("both_wvalid2", 32'(mem_bus.mem_write_valid), 0);
      mem_bus.mem_write_ready = 1'b0;
      mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 8'h5C; tick();
      mem_bus.mem_read_ready = 1'b0;
      chk("both_done", 32'(lsu_state), 3);
      chk("both_out", 32'(lsu_out), 32'h5C);
      cu_state = 4'd6; tick();
      cu_state = 4'd0; tick();

      // Disabled lane through a full load sequence
      enable = 1'b0; mem_ren = 1'b1; rs1_data = 8'h77;
      mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 8'hFF;
      for (int i = 3; i <= 7; i++) begin
         cu_state = 4'(i); tick();
         chk("dis_state", 32'(lsu_state), 0);
         chk("dis_rvalid", 32'(mem_bus.mem_read_valid), 0);
      end
      chk("dis_out", 32'(lsu_out), 32'h5C);
      enable = 1'b1; mem_ren = 1'b0; mem_bus.mem_read_ready = 1'b0;
      cu_state = 4'd0; tick();

      // Abort: compute unit back to IDLE while waiting
      cu_state = 4'd3; mem_ren = 1'b1; rs1_data = 8'h55; tick();
      cu_state = 4'd4; mem_ren = 1'b0; tick();
      chk("ab_wait", 32'(lsu_state), 2);
      cu_state = 4'd0; mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 8'h3C; tick();
      mem_bus.mem_read_ready = 1'b0;
      chk("ab_idle", 32'(lsu_state), 0);
      chk("ab_rvalid", 32'(mem_bus.mem_read_valid), 0);
      chk("ab_out", 32'(lsu_out), 32'h5C);

      // Reset pulse during WAIT with ready high on the same edge
      cu_state = 4'd3; mem_ren = 1'b1; rs1_data = 8'h44; tick();
      cu_state = 4'd4; mem_ren = 1'b0; tick();
      chk("rw_wait", 32'(lsu_state), 2);
      reset = 1'b1; mem_bus.mem_read_ready = 1'b1; mem_bus.mem_read_data = 8'hEE; tick();
      reset = 1'b0; mem_bus.mem_read_ready = 1'b0;
      chk("rw_state", 32'(lsu_state), 0);
      chk("rw_rvalid", 32'(mem_bus.mem_read_valid), 0);
      chk("rw_raddr", 32'(mem_bus.mem_read_addr), 0);
      chk("rw_out", 32'(lsu_out), 0);
      chk("rw_err", 32'(lsu_error), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
